// File: rtl/issue_scheduler.sv
// issue_scheduler: single-bank out-of-order ALU issue scheduler with wakeup
// tracking and a registered valid/ready issue port.
// Optional feature macro: ISQ_OLDEST_FIRST_EN selects oldest-first arbitration
// through an age matrix; when undefined the lowest ready index wins.

package common;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
   } alu_cmd_t;
   typedef enum logic [1:0] {OP_REG = 2'd0, OP_IMM, OP_PC, OP_ZERO} op_type_t;
endpackage

module issue_scheduler
   import common::*;
#(
   parameter int unsigned ENTRIES              = 8,
   parameter int unsigned PHYS_REGS_ADDR_WIDTH = 6,
   parameter int unsigned ROB_ADDR_WIDTH       = 5,
   parameter int unsigned DISPATCH_ADDR_WIDTH  = 1,
   parameter int unsigned BANK_ID              = 0,
   parameter int unsigned WB_WIDTH             = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush,
   input  logic                              disp_valid,
   output logic                              disp_ready,
   input  alu_cmd_t                          disp_alu_cmd,
   input  logic [PHYS_REGS_ADDR_WIDTH-1:0]   disp_op1,
   input  logic                              disp_op1_ready,
   input  op_type_t                          disp_op2_type,
   input  logic [31:0]                       disp_op2,
   input  logic                              disp_op2_ready,
   input  logic [PHYS_REGS_ADDR_WIDTH-1:0]   disp_phys_rd,
   input  logic [ROB_ADDR_WIDTH-1:0]         disp_rob_addr,
   input  logic [WB_WIDTH-1:0]               wb_valid,
   input  logic [PHYS_REGS_ADDR_WIDTH-1:0]   wb_phys_rd [WB_WIDTH],
   output logic                              iss_valid,
   input  logic                              iss_ready,
   output alu_cmd_t                          iss_alu_cmd,
   output logic [PHYS_REGS_ADDR_WIDTH-1:0]   iss_op1,
   output op_type_t                          iss_op2_type,
   output logic [31:0]                       iss_op2,
   output logic [PHYS_REGS_ADDR_WIDTH-1:0]   iss_phys_rd,
   output logic [DISPATCH_ADDR_WIDTH-1:0]    iss_bank_addr,
   output logic [ROB_ADDR_WIDTH-1:0]         iss_rob_addr,
   output logic [$clog2(ENTRIES):0]          count
);

   localparam int unsigned PW = PHYS_REGS_ADDR_WIDTH;
   localparam int unsigned RW = ROB_ADDR_WIDTH;
   localparam int unsigned IW = $clog2(ENTRIES);
   localparam int unsigned CW = IW + 1;

   typedef struct packed {
      alu_cmd_t    alu_cmd;
      logic [PW-1:0] op1;
      op_type_t    op2_type;
      logic [31:0] op2;
      logic [PW-1:0] phys_rd;
      logic [RW-1:0] rob_addr;
   } entry_t;

   entry_t              ent_q [ENTRIES];
   entry_t              ent_d [ENTRIES];
   logic [ENTRIES-1:0]  vld_q, vld_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
   entry_t              iss_q, iss_d;
   logic                iss_valid_q, iss_valid_d;
   logic [CW-1:0]       count_q, count_d;

   logic [ENTRIES-1:0]  req;
   logic [IW-1:0]       free_idx, win_idx;
   logic                win_found;
   logic                alloc, load, sel;
   entry_t              disp_ent;

   // True when any active writeback port broadcasts the given tag
   function automatic logic wake_hit(input logic [PW-1:0] tag);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < WB_WIDTH; k++)
         if (wb_valid[k] && (wb_phys_rd[k] == tag)) hit = 1'b1;
      return hit;
   endfunction

   assign req        = vld_q & rdy1_q & rdy2_q;
   assign disp_ready = (count_q < CW'(ENTRIES));
   assign alloc      = disp_valid && disp_ready && !flush;
   assign load       = !iss_valid_q || iss_ready;
   assign sel        = load && win_found;

   assign disp_ent.alu_cmd  = disp_alu_cmd;
   assign disp_ent.op1      = disp_op1;
   assign disp_ent.op2_type = disp_op2_type;
   assign disp_ent.op2      = disp_op2;
   assign disp_ent.phys_rd  = disp_phys_rd;
   assign disp_ent.rob_addr = disp_rob_addr;

   // Lowest-index free slot for allocation
   always_comb begin
      free_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--)
         if (!vld_q[i]) free_idx = IW'(i);
   end

`ifdef ISQ_OLDEST_FIRST_EN
   // age_q[i][j] set means entry j is older than entry i
   logic [ENTRIES-1:0] age_q [ENTRIES];
   logic [ENTRIES-1:0] age_d [ENTRIES];

   // Oldest requester: no older entry is also requesting
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < ENTRIES; i++)
         if (!win_found && req[i] && ((req & age_q[i]) == '0)) begin
            win_found = 1'b1;
            win_idx   = IW'(i);
         end
   end

   // New row snapshots current occupancy; freed entries drop out of every row
   always_comb begin
      age_d = age_q;
      if (alloc) age_d[free_idx] = vld_q;
      if (sel)
         for (int i = 0; i < ENTRIES; i++) age_d[i][win_idx] = 1'b0;
      if (flush)
         for (int i = 0; i < ENTRIES; i++) age_d[i] = '0;
   end

   // Age matrix register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) age_q[i] <= '0;
      end else begin
         age_q <= age_d;
      end
   end
`else
   // Fixed priority: lowest ready index wins
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < ENTRIES; i++)
         if (!win_found && req[i]) begin
            win_found = 1'b1;
            win_idx   = IW'(i);
         end
   end
`endif

   // Entry, readiness, output register and occupancy next state
   always_comb begin
      vld_d       = vld_q;
      rdy1_d      = rdy1_q;
      rdy2_d      = rdy2_q;
      ent_d       = ent_q;
      iss_d       = iss_q;
      iss_valid_d = iss_valid_q;
      count_d     = count_q;
      for (int i = 0; i < ENTRIES; i++)
         if (vld_q[i]) begin
            if (wake_hit(ent_q[i].op1))         rdy1_d[i] = 1'b1;
            if (wake_hit(ent_q[i].op2[PW-1:0])) rdy2_d[i] = 1'b1;
         end
      if (load) begin
         if (win_found) begin
            iss_d          = ent_q[win_idx];
            iss_valid_d    = 1'b1;
            vld_d[win_idx] = 1'b0;
         end else begin
            iss_valid_d = 1'b0;
         end
      end
      if (alloc) begin
         ent_d[free_idx]  = disp_ent;
         vld_d[free_idx]  = 1'b1;
         rdy1_d[free_idx] = disp_op1_ready | wake_hit(disp_op1);
         rdy2_d[free_idx] = disp_op2_ready | wake_hit(disp_op2[PW-1:0]);
      end
      count_d = count_q + CW'(alloc) - CW'(sel);
      if (flush) begin
         vld_d       = '0;
         iss_valid_d = 1'b0;
         count_d     = '0;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q       <= '0;
         rdy1_q      <= '0;
         rdy2_q      <= '0;
         iss_q       <= '0;
         iss_valid_q <= 1'b0;
         count_q     <= '0;
         for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
      end else begin
         vld_q       <= vld_d;
         rdy1_q      <= rdy1_d;
         rdy2_q      <= rdy2_d;
         iss_q       <= iss_d;
         iss_valid_q <= iss_valid_d;
         count_q     <= count_d;
         ent_q       <= ent_d;
      end
   end

   assign iss_valid     = iss_valid_q;
   assign iss_alu_cmd   = iss_q.alu_cmd;
   assign iss_op1       = iss_q.op1;
   assign iss_op2_type  = iss_q.op2_type;
   assign iss_op2       = iss_q.op2;
   assign iss_phys_rd   = iss_q.phys_rd;
   assign iss_rob_addr  = iss_q.rob_addr;
   assign iss_bank_addr = DISPATCH_ADDR_WIDTH'(BANK_ID);
   assign count         = count_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler; expected issue order depends on
// ISQ_OLDEST_FIRST_EN in the same way as the design.

module tb_issue_scheduler;
   import common::*;

   localparam int unsigned ENTRIES = 8;
   localparam int unsigned PW      = 6;
   localparam int unsigned RW      = 5;
   localparam int unsigned WBW     = 2;

   logic            clk, rst, flush;
   logic            disp_valid, disp_ready;
   alu_cmd_t        disp_alu_cmd;
   logic [PW-1:0]   disp_op1;
   logic            disp_op1_ready;
   op_type_t        disp_op2_type;
   logic [31:0]     disp_op2;
   logic            disp_op2_ready;
   logic [PW-1:0]   disp_phys_rd;
   logic [RW-1:0]   disp_rob_addr;
   logic [WBW-1:0]  wb_valid;
   logic [PW-1:0]   wb_phys_rd [WBW];
   logic            iss_valid, iss_ready;
   alu_cmd_t        iss_alu_cmd;
   logic [PW-1:0]   iss_op1;
   op_type_t        iss_op2_type;
   logic [31:0]     iss_op2;
   logic [PW-1:0]   iss_phys_rd;
   logic [0:0]      iss_bank_addr;
   logic [RW-1:0]   iss_rob_addr;
   logic [3:0]      count;

   issue_scheduler #(
      .ENTRIES(ENTRIES), .PHYS_REGS_ADDR_WIDTH(PW), .ROB_ADDR_WIDTH(RW),
      .DISPATCH_ADDR_WIDTH(1), .BANK_ID(0), .WB_WIDTH(WBW)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_alu_cmd(disp_alu_cmd), .disp_op1(disp_op1),
      .disp_op1_ready(disp_op1_ready), .disp_op2_type(disp_op2_type),
      .disp_op2(disp_op2), .disp_op2_ready(disp_op2_ready),
      .disp_phys_rd(disp_phys_rd), .disp_rob_addr(disp_rob_addr),
      .wb_valid(wb_valid), .wb_phys_rd(wb_phys_rd),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_alu_cmd(iss_alu_cmd), .iss_op1(iss_op1),
      .iss_op2_type(iss_op2_type), .iss_op2(iss_op2),
      .iss_phys_rd(iss_phys_rd), .iss_bank_addr(iss_bank_addr),
      .iss_rob_addr(iss_rob_addr), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [RW-1:0] rob;
      logic [PW-1:0] rd;
      logic [PW-1:0] op1;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   // Each accepted issue pops the next expected op
   always @(negedge clk) begin
      if (!rst && iss_valid && iss_ready) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("iss_rob", 32'(iss_rob_addr), 32'(mon_e.rob));
            check("iss_rd", 32'(iss_phys_rd), 32'(mon_e.rd));
            check("iss_op1", 32'(iss_op1), 32'(mon_e.op1));
            check("iss_bank", 32'(iss_bank_addr), 32'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int rob, input int rd, input int op1, input bit op1_rdy);
      disp_valid     = 1'b1;
      disp_alu_cmd   = ALU_SUB;
      disp_op1       = PW'(op1);
      disp_op1_ready = op1_rdy;
      disp_op2_type  = OP_IMM;
      disp_op2       = 32'h0000_A500 + 32'(rob);
      disp_op2_ready = 1'b1;
      disp_phys_rd   = PW'(rd);
      disp_rob_addr  = RW'(rob);
   endtask

   task automatic push(input int rob, input int rd, input int op1);
      exp_t e;
      e.rob = RW'(rob);
      e.rd  = PW'(rd);
      e.op1 = PW'(op1);
      sb.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0;
      drive(0, 0, 0, 1'b0);
      disp_valid = 1'b0;
      wb_valid = '0; wb_phys_rd[0] = '0; wb_phys_rd[1] = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_iss_valid", 32'(iss_valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_disp_ready", 32'(disp_ready), 32'd1);
      check("rst_iss_rob", 32'(iss_rob_addr), 32'd0);
      rst = 1'b0;
      iss_ready = 1'b1;

      // single op, minimum latency
      drive(3, 7, 1, 1'b1); push(3, 7, 1);
      tick(); disp_valid = 1'b0;
      check("single_t1_valid", 32'(iss_valid), 32'd0);
      check("single_t1_count", 32'(count), 32'd1);
      tick();
      check("single_t2_valid", 32'(iss_valid), 32'd1);
      check("single_t2_count", 32'(count), 32'd0);
      tick();
      check("single_t3_valid", 32'(iss_valid), 32'd0);

      // wakeup of a pending source
      drive(4, 8, 12, 1'b0); push(4, 8, 12);
      tick(); disp_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("wake_hold", 32'(iss_valid), 32'd0);
      end
      wb_valid = 2'b10; wb_phys_rd[1] = 6'd12;
      tick(); wb_valid = '0;
      check("wake_t1", 32'(iss_valid), 32'd0);
      tick();
      check("wake_t2", 32'(iss_valid), 32'd1);
      tick();

      // wakeup in the dispatch cycle
      drive(5, 9, 9, 1'b0); push(5, 9, 9);
      wb_valid = 2'b01; wb_phys_rd[0] = 6'd9;
      tick(); disp_valid = 1'b0; wb_valid = '0;
      check("same_t1", 32'(iss_valid), 32'd0);
      tick();
      check("same_t2", 32'(iss_valid), 32'd1);
      tick();

      // fill under backpressure: op10 sits in the output register, op11..op18 fill entries
      iss_ready = 1'b0;
      for (int n = 0; n < 9; n++) begin
         drive(10 + n, 20 + n, 1, 1'b1);
         tick();
      end
      disp_valid = 1'b0;
      push(10, 20, 1);
`ifdef ISQ_OLDEST_FIRST_EN
      push(11, 21, 1); push(12, 22, 1);
`else
      // op12 reused entry 0 freed when op10 loaded into the output register
      push(12, 22, 1); push(11, 21, 1);
`endif
      for (int n = 3; n < 9; n++) push(10 + n, 20 + n, 1);
      check("full_count", 32'(count), 32'd8);
      check("full_disp_ready", 32'(disp_ready), 32'd0);
      check("full_iss_valid", 32'(iss_valid), 32'd1);
      iss_ready = 1'b1;
      tick();
      check("bp_disp_ready", 32'(disp_ready), 32'd1);
      check("bp_count", 32'(count), 32'd7);
      check("bp_stream", 32'(iss_valid), 32'd1);
      for (int k = 2; k <= 8; k++) begin
         tick();
         check("bp_stream", 32'(iss_valid), 32'd1);
      end
      tick();
      check("bp_end_valid", 32'(iss_valid), 32'd0);
      check("bp_end_count", 32'(count), 32'd0);

      // select order: A in entry 5, entries 0-4 freed, then B in entry 0
      for (int n = 0; n < 5; n++) begin
         drive(20 + n, 30 + n, 30, 1'b0);
         push(20 + n, 30 + n, 30);
         tick();
      end
      drive(25, 40, 20, 1'b0);
      tick(); disp_valid = 1'b0;
      check("order_fill_count", 32'(count), 32'd6);
      wb_valid = 2'b01; wb_phys_rd[0] = 6'd30;
      tick(); wb_valid = '0;
      repeat (7) tick();
      check("order_a_only", 32'(count), 32'd1);
      check("order_a_idle", 32'(iss_valid), 32'd0);
      drive(26, 41, 20, 1'b0);
      tick(); disp_valid = 1'b0;
      check("order_ab_count", 32'(count), 32'd2);
`ifdef ISQ_OLDEST_FIRST_EN
      push(25, 40, 20); push(26, 41, 20);
`else
      push(26, 41, 20); push(25, 40, 20);
`endif
      wb_valid = 2'b10; wb_phys_rd[1] = 6'd20;
      tick(); wb_valid = '0;
      repeat (4) tick();
      check("order_done_count", 32'(count), 32'd0);

      // flush while the output register is stalled
      iss_ready = 1'b0;
      for (int n = 0; n < 5; n++) begin
         drive(n, n, 1, 1'b1);
         tick();
      end
      disp_valid = 1'b0;
      check("flush_pre_count", 32'(count), 32'd4);
      check("flush_pre_valid", 32'(iss_valid), 32'd1);
      flush = 1'b1;
      tick(); flush = 1'b0;
      check("flush_valid", 32'(iss_valid), 32'd0);
      check("flush_count", 32'(count), 32'd0);
      check("flush_disp_ready", 32'(disp_ready), 32'd1);
      iss_ready = 1'b1;
      repeat (2) tick();
      check("flush_idle", 32'(iss_valid), 32'd0);

      // asynchronous reset mid-stream
      iss_ready = 1'b0;
      for (int n = 1; n < 4; n++) begin
         drive(n, n, 2, 1'b1);
         tick();
      end
      disp_valid = 1'b0;
      check("arst_pre_valid", 32'(iss_valid), 32'd1);
      check("arst_pre_count", 32'(count), 32'd2);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", 32'(iss_valid), 32'd0);
      check("arst_count", 32'(count), 32'd0);
      check("arst_disp_ready", 32'(disp_ready), 32'd1);
      check("arst_rob", 32'(iss_rob_addr), 32'd0);
      tick();
      rst = 1'b0;
      iss_ready = 1'b1;

      // resume after reset
      drive(2, 5, 3, 1'b1); push(2, 5, 3);
      tick(); disp_valid = 1'b0;
      tick();
      check("resume_valid", 32'(iss_valid), 32'd1);
      tick();

      for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
      check("sb_drain", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Single-bank out-of-order issue scheduler between dispatch and one executer lane. Holds up to `ENTRIES` renamed ALU micro-ops and tracks source-operand readiness through writeback wakeup broadcasts. Each cycle it selects one ready entry and presents it on a registered valid/ready issue port whose fields match the issue queue → executer bundle: alu_cmd, op1, op2_type, op2, phys_rd, bank_addr, rob_addr.

## Interface
- `ENTRIES`, 8: scheduler depth; power of two, ≥2.
- `PHYS_REGS_ADDR_WIDTH`, 6: physical register tag width.
- `ROB_ADDR_WIDTH`, 5: ROB index width.
- `DISPATCH_ADDR_WIDTH`, 1: bank address width.
- `BANK_ID`, 0: constant driven on `iss_bank_addr`.
- `WB_WIDTH`, 2: number of wakeup broadcast ports.

- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of all entries and the output register.
- `disp_valid` in 1: dispatch request.
- `disp_ready` out 1: `count < ENTRIES`.
- `disp_alu_cmd` in common::alu_cmd_t: ALU command.
- `disp_op1` in PHYS_REGS_ADDR_WIDTH: source-1 tag.
- `disp_op1_ready` in 1: source 1 already available.
- `disp_op2_type` in common::op_type_t: operand-2 kind.
- `disp_op2` in 32: immediate, or tag in bits [PHYS_REGS_ADDR_WIDTH-1:0].
- `disp_op2_ready` in 1: source 2 available; the dispatcher drives 1 for non-register op2.
- `disp_phys_rd` in PHYS_REGS_ADDR_WIDTH: destination tag.
- `disp_rob_addr` in ROB_ADDR_WIDTH: ROB index.
- `wb_valid` in [WB_WIDTH]: wakeup strobes.
- `wb_phys_rd` in [WB_WIDTH]×PHYS_REGS_ADDR_WIDTH: wakeup tags.
- `iss_valid` out 1: issue output register valid.
- `iss_ready` in 1: executer accepts.
- `iss_alu_cmd`, `iss_op1`, `iss_op2_type`, `iss_op2`, `iss_phys_rd`, `iss_rob_addr` out: registered copies of the entry fields.
- `iss_bank_addr` out DISPATCH_ADDR_WIDTH: constant `BANK_ID`.
- `count` out $clog2(ENTRIES)+1: occupied entries, excluding the output register.

## Operation
- **Entry state:** `vld`, `rdy1`, `rdy2`, and the payload fields.
- **Allocate:** on `disp_valid && disp_ready && !flush`, write the lowest-index free entry.
  - `rdy1 = disp_op1_ready | (any wb_valid[k] && wb_phys_rd[k]==disp_op1)`.
  - `rdy2` is computed the same way against `disp_op2[PHYS_REGS_ADDR_WIDTH-1:0]`.
  - This same-cycle wakeup capture is mandatory.
- **Wakeup:** each valid entry with `rdy1==0` whose op1 tag matches any valid `wb_phys_rd` sets `rdy1`. The same rule applies to `rdy2`. Ready bits never clear while the entry is valid.
- **Request:** an entry requests issue when `vld && rdy1 && rdy2`. Readiness is the registered state; a wakeup in cycle t makes the entry eligible in cycle t+1.
- **Select:** one winner per cycle, per Configuration.
- **Output register load:** when `!iss_valid || iss_ready`:
  - the winner's payload loads into the output register and the winner's `vld` clears;
  - with no winner, `iss_valid` goes 0.
- **Output register hold:** when `iss_valid && !iss_ready`, the register and all entries stay unchanged.
- **Count:** `count` += allocate, −= select-load; both can occur in the same cycle.
- **Full:** allocate and select in the same cycle while full is not permitted, because `disp_ready` derives from registered `count`.
- **Flush:** clears all `vld`, `iss_valid`, and `count` at the next edge. Flush overrides dispatch and wakeup in that cycle.
- **Reset values:** all `vld`, `rdy*`, `iss_valid`, and `count` = 0; `iss_*` payloads = 0; `disp_ready` = 1.

## Timing
- **Dispatch to issue:** dispatch with ready sources in cycle t → entry valid at t+1 → selected in t+1 → `iss_valid` in t+2. Minimum latency is 2.
- **Wakeup to issue:** wakeup in cycle t for the last pending source → `iss_valid` no earlier than t+2.
- **Throughput:** one issue per cycle with `iss_ready` held high.
- **Backpressure:** `iss_ready` low stalls selection with no loss of data.
- **Asynchronous reset:** `rst` asserted mid-operation clears state immediately. Operation resumes on the first edge after `rst` deasserts.

## Configuration
- **`ISQ_OLDEST_FIRST_EN` defined:** oldest-first select using an ENTRIES×ENTRIES age matrix.
  - On allocate of entry i, row i = current `vld` vector, marking the entries older than i.
  - Column i clears on free.
  - The winner is the requesting entry with no older requesting entry.
- **`ISQ_OLDEST_FIRST_EN` undefined:** fixed priority, lowest index wins. No age matrix is built.

## Test plan
- **Single op:** reset, then dispatch one op with both sources ready, rob 3, rd 7 → `iss_valid` = 1 exactly 2 cycles later with `iss_rob_addr` = 3, `iss_phys_rd` = 7; `count` returns to 0.
- **Wakeup:** dispatch op with op1 tag 12 not ready; hold 5 cycles with no issue; pulse `wb_valid[1]` with tag 12 at cycle t → `iss_valid` at t+2.
- **Same-cycle wakeup:** dispatch with op1 tag 9 not ready while `wb_phys_rd[0]` = 9 valid in the same cycle → issues at minimum latency, no hang.
- **Full and backpressure:** fill 8 entries with `iss_ready` = 0 → `disp_ready` = 0 and `count` = 8; raise `iss_ready` → 8 issues on consecutive cycles, `disp_ready` reasserts one cycle after the first select.
- **Select order:** with `ISQ_OLDEST_FIRST_EN`, dispatch A into entry 5 (entries 0-4 later freed), then B into entry 0; wake both together → A issues first. Without the macro → B issues first.
- **Flush:** flush during a stalled `iss_valid` with 4 entries pending → next cycle `iss_valid` = 0 and `count` = 0. Assert `rst` mid-stream → outputs clear without waiting for a clock edge.
